uart_tx_sched: RTL and testbench

Transmit scheduler for the UART transmitter. Two byte producers (CPU bus port 0 and debug/trace port 1) share one UART TX channel through round-robin arbitration into a shared byte FIFO. A drain state machine feeds the transmitter one byte at a time over its `tx_start`/`tx_data`/`tx_busy`/`tx_end` handshake. The block sits between the bus-side producers and the `uart_tx` instance.

---
 rtl/uart_tx_sched.sv | 131 +++++++++++++
 tb/tb_uart_tx_sched.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_sched.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_sched
// Purpose  : Round-robin arbitration of two byte producers into a shared FIFO,
//            drained one byte at a time into a UART transmitter.
// Revision : 1.0
// ============================================================================
module uart_tx_sched #(
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req0_valid,
    input  logic [7:0]    req0_data,
    output logic          req0_ready,
    input  logic          req1_valid,
    input  logic [7:0]    req1_data,
    output logic          req1_ready,
    input  logic          flush,
    output logic          tx_start,
    output logic [7:0]    tx_data,
    input  logic          tx_busy,
    input  logic          tx_end,
    output logic [AW:0]   fifo_count,
    output logic          fifo_empty,
    output logic          fifo_full
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    localparam logic [AW-1:0] PTR_ONE   = AW'(1);
    localparam logic [AW:0]   CNT_DEPTH = (AW+1)'(DEPTH);

    state_t          state_q, state_d;
    logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [AW:0]     count_q, count_d;
    logic            last1_q;
    logic            tx_start_q;
    logic [7:0]      tx_data_q;
    logic [7:0]      mem_q [DEPTH];

    logic            w_can_push;
    logic            w_grant1;
    logic            w_push;
    logic            w_pop;
    logic [7:0]      w_push_data;

    assign fifo_count = count_q;
    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == CNT_DEPTH);
    assign tx_start   = tx_start_q;
    assign tx_data    = tx_data_q;

    // last1_q remembers the port granted on the last accepted push; on a tie
    // the other port wins.
    always_comb begin
        w_can_push = !fifo_full && !flush;
        if (req0_valid && req1_valid) begin
            w_grant1 = !last1_q;
        end else begin
            w_grant1 = req1_valid;
        end
        req0_ready  = w_can_push && req0_valid && !w_grant1;
        req1_ready  = w_can_push && req1_valid && w_grant1;
        w_push      = req0_ready || req1_ready;
        w_push_data = req1_ready ? req1_data : req0_data;
    end

    always_comb begin
        state_d = state_q;
        w_pop   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty && !tx_busy && !flush) begin
                    w_pop   = 1'b1;
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (tx_end) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        count_d = count_q + (AW+1)'(w_push) - (AW+1)'(w_pop);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            last1_q    <= 1'b1;
            tx_start_q <= 1'b0;
            tx_data_q  <= 8'h00;
        end else begin
            state_q    <= state_d;
            tx_start_q <= w_pop;
            if (w_pop) begin
                tx_data_q <= mem_q[rd_ptr_q];
            end
            if (w_push) begin
                last1_q <= req1_ready;
            end
            // A flush outranks the pointer updates; the in-flight byte is left alone.
            if (flush) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
                count_q  <= '0;
            end else begin
                if (w_push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
                if (w_pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
                count_q <= count_d;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            mem_q[wr_ptr_q] <= w_push_data;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx_sched
// Purpose  : Randomised and directed bench for uart_tx_sched with a queue-based
//            reference model and a start/data scoreboard.
// Revision : 1.0
// ============================================================================
module tb_uart_tx_sched;

    localparam int DEPTH = 8;
    localparam int AW    = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req0_valid = 1'b0, req1_valid = 1'b0;
    logic [7:0]    req0_data = 8'h00, req1_data = 8'h00;
    logic          req0_ready, req1_ready;
    logic          flush = 1'b0;
    logic          tx_start;
    logic [7:0]    tx_data;
    logic          tx_busy = 1'b0, tx_end = 1'b0;
    logic [AW:0]   fifo_count;
    logic          fifo_empty, fifo_full;

    uart_tx_sched #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
        .flush(flush), .tx_start(tx_start), .tx_data(tx_data),
        .tx_busy(tx_busy), .tx_end(tx_end),
        .fifo_count(fifo_count), .fifo_empty(fifo_empty), .fifo_full(fifo_full)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model: queued bytes, last granted port, drain status.
    logic [7:0] mq[$];
    logic [7:0] exp_q[$];
    bit         m_last1 = 1'b1;
    bit         m_wait  = 1'b0;
    bit         m_start = 1'b0;
    logic [7:0] m_data  = 8'h00;
    bit         g_e0, g_e1;
    // Transmitter stub: busy for s_cnt cycles after each observed start.
    bit         s_busy = 1'b0;
    int         s_cnt  = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (tx_start === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL sb_unexpected_start actual=%0h required=none", tx_data);
            end else begin
                logic [7:0] e;
                e = exp_q.pop_front();
                if (tx_data !== e) begin
                    failures++;
                    $display("FAIL sb_tx_data actual=%0h required=%0h", tx_data, e);
                end
            end
        end
    end

    // One clock cycle: drive inputs just after a falling edge, check the
    // combinational readies, advance the model across the rising edge, then
    // check the registered outputs at the next falling edge.
    task automatic step(input bit v0, input logic [7:0] d0, input bit v1, input logic [7:0] d1,
                        input bit fl, input bit rs, input bit bx, input bit stray);
        bit can, pop, bsy, te;
        rst        = rs;
        flush      = fl;
        req0_valid = v0; req0_data = d0;
        req1_valid = v1; req1_data = d1;
        bsy        = s_busy || bx;
        te         = (s_busy && s_cnt == 0) || stray;
        tx_busy    = bsy;
        tx_end     = te;
        #1;
        can  = (mq.size() < DEPTH) && !fl;
        g_e0 = can && v0 && (!v1 || m_last1);
        g_e1 = can && v1 && (!v0 || !m_last1);
        chk("req0_ready", req0_ready, g_e0);
        chk("req1_ready", req1_ready, g_e1);
        @(posedge clk);
        if (s_busy && s_cnt == 0) s_busy = 1'b0;
        if (rs) begin
            mq.delete();
            m_last1 = 1'b1; m_wait = 1'b0; m_start = 1'b0; m_data = 8'h00;
            g_e0 = 1'b0; g_e1 = 1'b0;
        end else begin
            pop     = !m_wait && mq.size() > 0 && !bsy && !fl;
            m_start = pop;
            if (pop) begin
                m_data = mq.pop_front();
                exp_q.push_back(m_data);
                m_wait = 1'b1;
            end else if (m_wait && te) begin
                m_wait = 1'b0;
            end
            if (fl) begin
                mq.delete();
            end else if (g_e0) begin
                mq.push_back(d0); m_last1 = 1'b0;
            end else if (g_e1) begin
                mq.push_back(d1); m_last1 = 1'b1;
            end
        end
        @(negedge clk);
        chk("tx_start", tx_start, m_start);
        chk("tx_data", tx_data, m_data);
        chk("fifo_count", fifo_count, mq.size());
        chk("fifo_empty", fifo_empty, mq.size() == 0);
        chk("fifo_full", fifo_full, mq.size() == DEPTH);
        if (tx_start === 1'b1) begin
            s_busy = 1'b1;
            s_cnt  = $urandom_range(1, 6);
        end else if (s_busy && s_cnt > 0) begin
            s_cnt--;
        end
    endtask

    task automatic idle(input int n, input bit bx);
        for (int i = 0; i < n; i++) step(0, 8'h00, 0, 8'h00, 0, 0, bx, 0);
    endtask

    initial begin
        int i0, i1;
        @(negedge clk);
        step(0, 8'h00, 0, 8'h00, 0, 1, 0, 0);
        step(0, 8'h00, 0, 8'h00, 0, 1, 0, 0);
        chk("reset_count", fifo_count, 0);
        chk("reset_empty", fifo_empty, 1);
        chk("reset_tx_data", tx_data, 8'h00);

        // Single byte
        step(1, 8'hA5, 0, 8'h00, 0, 0, 0, 0);
        chk("single_count", fifo_count, 1);
        step(0, 8'h00, 0, 8'h00, 0, 0, 0, 0);
        chk("single_start", tx_start, 1);
        chk("single_data", tx_data, 8'hA5);
        idle(12, 0);

        // Round-robin fill with the drain stalled
        i0 = 0; i1 = 0;
        for (int k = 0; k < 10; k++) begin
            step(1, 8'h10 + 8'(i0), 1, 8'h20 + 8'(i1), 0, 0, 1, 0);
            if (g_e0) i0++;
            if (g_e1) i1++;
        end
        chk("rr_full", fifo_full, 1);
        chk("rr_count", fifo_count, DEPTH);

        // Full boundary: pop and push attempt on the same edge, then push
        step(1, 8'h55, 0, 8'h00, 0, 0, 0, 0);
        step(1, 8'h56, 0, 8'h00, 0, 0, 0, 0);
        chk("full_count_hold", fifo_count, DEPTH);
        idle(80, 0);

        // Busy interlock
        step(1, 8'h3C, 0, 8'h00, 0, 0, 1, 0);
        idle(3, 1);
        chk("busy_no_start", tx_start, 0);
        step(0, 8'h00, 0, 8'h00, 0, 0, 0, 0);
        chk("busy_release_start", tx_start, 1);
        idle(12, 0);

        // Flush with one byte in flight
        for (int k = 0; k < 4; k++) step(1, 8'h40 + 8'(k), 0, 8'h00, 0, 0, 1, 0);
        idle(1, 0);
        step(0, 8'h00, 0, 8'h00, 1, 0, 0, 0);
        chk("flush_count", fifo_count, 0);
        chk("flush_empty", fifo_empty, 1);
        idle(15, 0);

        // Reset while waiting for the transmitter
        for (int k = 0; k < 4; k++) step(0, 8'h00, 1, 8'h60 + 8'(k), 0, 0, 1, 0);
        idle(1, 0);
        step(0, 8'h00, 0, 8'h00, 0, 1, 0, 0);
        chk("rstwait_count", fifo_count, 0);
        chk("rstwait_start", tx_start, 0);
        idle(15, 0);

        // Randomised traffic
        for (int k = 0; k < 3000; k++) begin
            step($urandom_range(0, 1), 8'($urandom), $urandom_range(0, 1), 8'($urandom),
                 $urandom_range(0, 39) == 0, $urandom_range(0, 299) == 0,
                 $urandom_range(0, 3) == 0, $urandom_range(0, 19) == 0);
        end
        idle(100, 0);
        chk("sb_drained", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
